door_sequencer: RTL and testbench
=================================

// Module: door_sequencer
// PURPOSE
//  Downstream of the elevator core/controller: turns the controller's open_door request into timed
//  door-motor commands. Sequences opening, dwell and closing; reopens on obstruction; issues a
//  one-cycle clear_req so the floor's latched calls are dropped. Reports door_closed as the motion interlock.
// PARAMETERS
//  CNT_W         8    width of the shared dwell/timeout counter
//  DWELL_CYCLES  50   cycles the door stays fully open before closing (< 2**CNT_W)
//  MOVE_TIMEOUT  20   max cycles allowed to reach a limit switch while opening/closing
//  MAX_REOPEN    3    obstruction reopens allowed per service before FAULT
// PORTS
//  clk             in   1  system clock, rising edge
//  reset           in   1  asynchronous, active-low reset
//  open_door       in   1  controller request to service the current floor (level)
//  stop            in   1  motor stopped; open is only legal when 1
//  obstruct        in   1  light-curtain obstruction sensor
//  hold_btn        in   1  in-car door-open button
//  lim_open        in   1  door fully-open limit switch
//  lim_closed      in   1  door fully-closed limit switch
//  door_motor_open out  1  drive door motor toward open
//  door_motor_close out 1  drive door motor toward closed
//  door_closed     out  1  door closed and idle; car may move
//  clear_req       out  1  1-cycle pulse: clear latched calls for current floor
//  fault           out  1  sticky fault flag; cleared only by reset
// BEHAVIOUR
//  - Reset (reset=0, async): state=CLOSED, counter=0, reopen count=0; all outputs 0 except door_closed=1.
//  - Motor outputs registered; door_motor_open and door_motor_close never both 1.
//  - CLOSED: door_closed=1. open_door&stop -> OPENING next cycle (counter=0). open_door&!stop ignored.
//  - OPENING: door_motor_open=1; counter++ per cycle. lim_open -> OPEN_DWELL, counter=0,
//    clear_req=1 for exactly that transition cycle. counter==MOVE_TIMEOUT-1 without lim_open -> FAULT.
//  - OPEN_DWELL: both motors 0; counter++. obstruct or hold_btn holds counter at 0.
//    counter==DWELL_CYCLES-1 -> CLOSING, counter=0.
//  - CLOSING: door_motor_close=1; counter++. obstruct or hold_btn -> OPENING, counter=0, reopen++.
//    reopen==MAX_REOPEN at that moment -> FAULT instead. lim_closed -> CLOSED, reopen=0.
//    Timeout as OPENING -> FAULT. Obstruction wins over lim_closed in the same cycle.
//  - FAULT: both motors 0, door_closed=0, fault=1; exits only on reset.
//  - open_door still high on return to CLOSED (call at same floor re-latched) -> reopens next cycle.
//  - lim_open and lim_closed both 1: treated as sensor error -> FAULT from any non-FAULT state.
//  - Counter saturates; never wraps. Reset mid-operation: immediate return to CLOSED state values,
//    motors off asynchronously.
// STRUCTURE
//  - Shared package elev_pkg: door state enum (CLOSED, OPENING, OPEN_DWELL, CLOSING, FAULT),
//    default DWELL_CYCLES/MOVE_TIMEOUT constants, sharable with core/controller.
//  - One sub-module: door_timer (loadable saturating up-counter, clr/hold/inc, terminal-count compare).
//  - FSM, reopen counter and output registers in door_sequencer top.
// TESTING
//  1. Normal service: stop=1, open_door pulse, lim_open after 5 cyc -> clear_req 1 cyc, dwell 50 cyc,
//     door_motor_close=1, lim_closed after 5 cyc -> door_closed=1, fault=0.
//  2. Moving request: stop=0, open_door=1 for 10 cyc -> door stays CLOSED, motors 0.
//  3. Obstruction while CLOSING x3 -> three reopens; 4th obstruction -> fault=1, motors 0 until reset.
//  4. hold_btn held 100 cyc in OPEN_DWELL -> no close; release -> CLOSING after exactly 50 cyc.
//  5. No lim_open within 20 cyc of OPENING -> fault=1; both limits high in CLOSED -> fault=1.
//  6. reset=0 mid-CLOSING, asynchronous to clk -> motors 0 immediately, door_closed=1 after release.

Source files
------------

// File: rtl/elev_pkg.sv
// -----------------------------------------------------------------------------
// elev_pkg
// Definitions shared by the elevator core, the controller and the door
// sequencer: the door state encoding, default door timing constants, the
// door output bundle and a helper that maps a door state onto that bundle.
// No ports (package).
// -----------------------------------------------------------------------------
package elev_pkg;

   // Default door timing, in clock cycles. The core/controller import these
   // so they can reason about door service time without duplicating numbers.
   localparam int DOOR_CNT_W_DEF       = 8;
   localparam int DWELL_CYCLES_DEF     = 50;
   localparam int MOVE_TIMEOUT_DEF     = 20;
   localparam int MAX_REOPEN_DEF       = 3;

   typedef enum logic [2:0] {
      DOOR_CLOSED     = 3'd0,
      DOOR_OPENING    = 3'd1,
      DOOR_OPEN_DWELL = 3'd2,
      DOOR_CLOSING    = 3'd3,
      DOOR_FAULT      = 3'd4
   } door_state_e;

   // Registered door outputs, kept together so they update as one word.
   typedef struct packed {
      logic motor_open;
      logic motor_close;
      logic door_closed;
      logic clear_req;
      logic fault;
   } door_out_t;

   // Output word held while in reset: door reported closed, everything else off.
   localparam door_out_t DOOR_OUT_RESET = '{
      motor_open:  1'b0,
      motor_close: 1'b0,
      door_closed: 1'b1,
      clear_req:   1'b0,
      fault:       1'b0
   };

   // Outputs are a pure function of the state being entered, so the two motor
   // drives can never be active together: each belongs to a different state.
   function automatic door_out_t door_out_for(input door_state_e st,
                                              input logic        clr_pulse);
      door_out_t o;
      o             = '0;
      o.motor_open  = (st == DOOR_OPENING);
      o.motor_close = (st == DOOR_CLOSING);
      o.door_closed = (st == DOOR_CLOSED);
      o.fault       = (st == DOOR_FAULT);
      o.clear_req   = clr_pulse;
      return o;
   endfunction

endpackage : elev_pkg

// File: rtl/door_timer.sv
// -----------------------------------------------------------------------------
// door_timer
// Loadable saturating up-counter shared by the door sequencer for both the
// motion timeout and the open dwell. Priority: clr > load > inc; with none of
// them asserted the count holds. The counter stops at all-ones rather than
// wrapping, so a stuck terminal compare can never be skipped past.
// Ports:
//   clk      in  1      clock, rising edge
//   rst_n    in  1      asynchronous active-low reset (count -> 0)
//   clr      in  1      synchronous clear to 0
//   load     in  1      synchronous load of load_val
//   load_val in  CNT_W  value loaded when load=1
//   inc      in  1      count up by one (saturating)
//   tc_val   in  CNT_W  terminal-count compare value
//   tc_hit   out 1      count == tc_val (combinational from the register)
// -----------------------------------------------------------------------------
module door_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             inc,
   input  logic [CNT_W-1:0] tc_val,
   output logic             tc_hit
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (load) begin
         count_d = load_val;
      end else if (inc && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc_hit = (count_q == tc_val);

endmodule : door_timer

// File: rtl/door_sequencer.sv
// -----------------------------------------------------------------------------
// door_sequencer
// Turns the controller's open_door request into timed door-motor commands:
// open until the open limit, dwell, close until the closed limit, reopen on
// obstruction (bounded by MAX_REOPEN), and latch a fault on timeout, on too
// many reopens, or on both limit switches reading active together.
// A one-cycle clear_req marks the moment the door reaches fully open so the
// controller can drop the latched calls for this floor.
// Ports:
//   clk              in  1  system clock, rising edge
//   reset            in  1  asynchronous active-low reset
//   open_door        in  1  service request for the current floor (level)
//   stop             in  1  car motor stopped; opening only allowed when 1
//   obstruct         in  1  light-curtain obstruction
//   hold_btn         in  1  in-car door-open button
//   lim_open         in  1  fully-open limit switch
//   lim_closed       in  1  fully-closed limit switch
//   door_motor_open  out 1  drive door toward open
//   door_motor_close out 1  drive door toward closed
//   door_closed      out 1  door closed and idle; car may move
//   clear_req        out 1  one-cycle pulse on reaching fully open
//   fault            out 1  sticky fault, cleared only by reset
// -----------------------------------------------------------------------------
module door_sequencer
   import elev_pkg::*;
#(
   parameter int CNT_W        = DOOR_CNT_W_DEF,
   parameter int DWELL_CYCLES = DWELL_CYCLES_DEF,
   parameter int MOVE_TIMEOUT = MOVE_TIMEOUT_DEF,
   parameter int MAX_REOPEN   = MAX_REOPEN_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic open_door,
   input  logic stop,
   input  logic obstruct,
   input  logic hold_btn,
   input  logic lim_open,
   input  logic lim_closed,
   output logic door_motor_open,
   output logic door_motor_close,
   output logic door_closed,
   output logic clear_req,
   output logic fault
);

   localparam int RW = (MAX_REOPEN < 1) ? 1 : $clog2(MAX_REOPEN + 1);

   localparam logic [CNT_W-1:0] MOVE_TC  = CNT_W'(MOVE_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] DWELL_TC = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [RW-1:0]    REOPEN_MAX = RW'(MAX_REOPEN);

   door_state_e      state_q;
   door_state_e      state_d;
   logic [RW-1:0]    reopen_q;
   logic [RW-1:0]    reopen_d;
   door_out_t        outs_q;
   door_out_t        outs_d;

   logic             tmr_clr;
   logic             tmr_inc;
   logic [CNT_W-1:0] tmr_tc_val;
   logic             tmr_tc_hit;
   logic             clear_pulse;

   logic             sensor_err;
   logic             door_blocked;

   // Both limits active at once is physically impossible; treat as a broken sensor.
   assign sensor_err   = lim_open & lim_closed;
   // The light curtain and the door-open button have the same effect everywhere.
   assign door_blocked = obstruct | hold_btn;

   door_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (reset),
      .clr      (tmr_clr),
      .load     (1'b0),
      .load_val ('0),
      .inc      (tmr_inc),
      .tc_val   (tmr_tc_val),
      .tc_hit   (tmr_tc_hit)
   );

   // ---------------------------------------------------------------------------
   // Next-state logic. The timer is cleared on every state change so each
   // state starts counting from 0; the cycle where the count equals the
   // terminal value is the last cycle spent in that state.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      reopen_d    = reopen_q;
      tmr_clr     = 1'b0;
      tmr_inc     = 1'b0;
      tmr_tc_val  = '0;
      clear_pulse = 1'b0;

      case (state_q)
         DOOR_CLOSED: begin
            tmr_clr = 1'b1;
            if (sensor_err) begin
               state_d = DOOR_FAULT;
            end else if (open_door && stop) begin
               // A still-asserted open_door after closing lands here too and
               // reopens on the next cycle (call re-latched at this floor).
               state_d = DOOR_OPENING;
            end
         end

         DOOR_OPENING: begin
            tmr_tc_val = MOVE_TC;
            if (sensor_err) begin
               state_d = DOOR_FAULT;
               tmr_clr = 1'b1;
            end else if (lim_open) begin
               state_d     = DOOR_OPEN_DWELL;
               tmr_clr     = 1'b1;
               clear_pulse = 1'b1;
            end else if (tmr_tc_hit) begin
               state_d = DOOR_FAULT;
               tmr_clr = 1'b1;
            end else begin
               tmr_inc = 1'b1;
            end
         end

         DOOR_OPEN_DWELL: begin
            tmr_tc_val = DWELL_TC;
            if (sensor_err) begin
               state_d = DOOR_FAULT;
               tmr_clr = 1'b1;
            end else if (door_blocked) begin
               // Restart the dwell from zero for as long as the door is blocked.
               tmr_clr = 1'b1;
            end else if (tmr_tc_hit) begin
               state_d = DOOR_CLOSING;
               tmr_clr = 1'b1;
            end else begin
               tmr_inc = 1'b1;
            end
         end

         DOOR_CLOSING: begin
            tmr_tc_val = MOVE_TC;
            if (sensor_err) begin
               state_d = DOOR_FAULT;
               tmr_clr = 1'b1;
            end else if (door_blocked) begin
               // Checked before lim_closed: a blocked doorway must never be
               // reported as closed even if the switch trips in the same cycle.
               tmr_clr = 1'b1;
               if (reopen_q == REOPEN_MAX) begin
                  state_d = DOOR_FAULT;
               end else begin
                  state_d  = DOOR_OPENING;
                  reopen_d = reopen_q + 1'b1;
               end
            end else if (lim_closed) begin
               state_d  = DOOR_CLOSED;
               reopen_d = '0;
               tmr_clr  = 1'b1;
            end else if (tmr_tc_hit) begin
               state_d = DOOR_FAULT;
               tmr_clr = 1'b1;
            end else begin
               tmr_inc = 1'b1;
            end
         end

         DOOR_FAULT: begin
            // Absorbing: only reset leaves this state.
            tmr_clr = 1'b1;
         end

         default: begin
            state_d = DOOR_FAULT;
            tmr_clr = 1'b1;
         end
      endcase
   end

   // Outputs are registered from the state being entered, so they change on
   // the same edge as the state itself.
   always_comb begin
      outs_d = door_out_for(state_d, clear_pulse);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= DOOR_CLOSED;
         reopen_q <= '0;
         outs_q   <= DOOR_OUT_RESET;
      end else begin
         state_q  <= state_d;
         reopen_q <= reopen_d;
         outs_q   <= outs_d;
      end
   end

   assign door_motor_open  = outs_q.motor_open;
   assign door_motor_close = outs_q.motor_close;
   assign door_closed      = outs_q.door_closed;
   assign clear_req        = outs_q.clear_req;
   assign fault            = outs_q.fault;

endmodule : door_sequencer

// File: tb/tb_door_sequencer.sv
// -----------------------------------------------------------------------------
// tb_door_sequencer
// Self-checking bench for door_sequencer. A table of steps {inputs, cycles,
// expected outputs} drives the main service scenarios; hand-written
// sequences cover timeout, sensor error and asynchronous reset. Expected
// output words go into exp_q when a step is driven and are popped and
// compared once the step's cycles have elapsed.
// Output word order: {door_motor_open, door_motor_close, door_closed,
//                     clear_req, fault}.
// -----------------------------------------------------------------------------
module tb_door_sequencer;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic open_door;
   logic stop;
   logic obstruct;
   logic hold_btn;
   logic lim_open;
   logic lim_closed;
   logic door_motor_open;
   logic door_motor_close;
   logic door_closed;
   logic clear_req;
   logic fault;

   door_sequencer dut (
      .clk              (clk),
      .reset            (reset),
      .open_door        (open_door),
      .stop             (stop),
      .obstruct         (obstruct),
      .hold_btn         (hold_btn),
      .lim_open         (lim_open),
      .lim_closed       (lim_closed),
      .door_motor_open  (door_motor_open),
      .door_motor_close (door_motor_close),
      .door_closed      (door_closed),
      .clear_req        (clear_req),
      .fault            (fault)
   );

   // Input word bits: {open_door, stop, obstruct, hold_btn, lim_open, lim_closed}
   localparam logic [5:0] I_NONE = 6'b000000;
   localparam logic [5:0] I_OPEN = 6'b100000;
   localparam logic [5:0] I_STOP = 6'b010000;
   localparam logic [5:0] I_OBS  = 6'b001000;
   localparam logic [5:0] I_HOLD = 6'b000100;
   localparam logic [5:0] I_LO   = 6'b000010;
   localparam logic [5:0] I_LC   = 6'b000001;

   localparam logic [4:0] O_NONE = 5'b00000;
   localparam logic [4:0] O_MO   = 5'b10000;
   localparam logic [4:0] O_MC   = 5'b01000;
   localparam logic [4:0] O_DC   = 5'b00100;
   localparam logic [4:0] O_CR   = 5'b00010;
   localparam logic [4:0] O_FT   = 5'b00001;

   localparam int DWELL = 50;
   localparam int MOVE  = 20;

   typedef struct {
      string      name;
      logic [5:0] in;
      int         cycles;
      logic [4:0] exp;
   } step_t;

   step_t      steps[$];
   logic [4:0] exp_q[$];
   int         checks = 0;
   int         errors = 0;

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [5:0] v);
      {open_door, stop, obstruct, hold_btn, lim_open, lim_closed} = v;
   endtask

   task automatic add(input string name, input logic [5:0] v, input int cycles,
                      input logic [4:0] exp);
      step_t s;
      s.name   = name;
      s.in     = v;
      s.cycles = cycles;
      s.exp    = exp;
      steps.push_back(s);
   endtask

   // ---------------- scoreboard ----------------
   task automatic compare_head(input string name);
      logic [4:0] got;
      logic [4:0] exp;
      got = {door_motor_open, door_motor_close, door_closed, clear_req, fault};
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: no expected value queued, got %b", name, got);
      end else begin
         exp = exp_q.pop_front();
         if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (mo mc dc cr ft)", name, got, exp);
         end
      end
   endtask

   // Drive one step: hold inputs for 'cycles' edges, checking the motor
   // interlock every cycle, then compare the outputs with the queued value.
   task automatic run_step(input string name, input logic [5:0] v, input int cycles,
                           input logic [4:0] exp);
      drive(v);
      exp_q.push_back(exp);
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk);
         #1;
         checks++;
         if (door_motor_open && door_motor_close) begin
            errors++;
            $display("FAIL %s_interlock: both motors 1 at cycle %0d, required not both", name, c);
         end
      end
      compare_head(name);
   endtask

   // Assert reset away from any clock edge, check outputs respond without a
   // clock, then release and check the idle closed state.
   task automatic async_reset(input string name);
      #2;
      reset = 1'b0;
      #1;
      exp_q.push_back(O_DC);
      compare_head({name, "_asserted"});
      drive(I_NONE);
      #3;
      reset = 1'b1;
      @(posedge clk);
      #1;
      exp_q.push_back(O_DC);
      compare_head({name, "_released"});
   endtask

   // ---------------- test ----------------
   initial begin
      logic [5:0] noise;

      drive(I_NONE);

      // Table: moving request ignored, normal service with re-latched call,
      // hold button in dwell, three obstruction reopens then fault.
      noise = ($urandom_range(0, 1) != 0 ? I_OBS : I_NONE) |
              ($urandom_range(0, 1) != 0 ? I_HOLD : I_NONE);
      add("moving_first",   I_OPEN | I_LC | noise,        1,        O_DC);
      add("moving_hold",    I_OPEN | I_LC | noise,        9,        O_DC);
      add("svc_start",      I_OPEN | I_STOP | I_LC,       1,        O_MO);
      add("svc_opening",    I_STOP,                       4,        O_MO);
      add("svc_lim_open",   I_STOP | I_LO,                1,        O_CR);
      add("svc_clr_one",    I_STOP | I_LO,                1,        O_NONE);
      add("svc_dwell_end",  I_STOP | I_LO,                DWELL-2,  O_NONE);
      add("svc_closing",    I_STOP,                       1,        O_MC);
      add("svc_closing4",   I_STOP,                       4,        O_MC);
      add("svc_closed",     I_OPEN | I_STOP | I_LC,       1,        O_DC);
      add("relatch_reopen", I_OPEN | I_STOP | I_LC,       1,        O_MO);
      add("hold_lim_open",  I_STOP | I_LO,                1,        O_CR);
      add("hold_100",       I_STOP | I_LO | I_HOLD,       100,      O_NONE);
      add("hold_rel_49",    I_STOP | I_LO,                DWELL-1,  O_NONE);
      add("hold_rel_50",    I_STOP,                       1,        O_MC);
      for (int r = 1; r <= 3; r++) begin
         // Second reopen also raises lim_closed: obstruction must win.
         add($sformatf("reopen%0d", r),
             I_STOP | I_OBS | (r == 2 ? I_LC : I_NONE),  1,        O_MO);
         add($sformatf("reopen%0d_open", r),  I_STOP | I_LO, 1,        O_CR);
         add($sformatf("reopen%0d_dwell", r), I_STOP | I_LO, DWELL-1,  O_NONE);
         add($sformatf("reopen%0d_close", r), I_STOP,        1,        O_MC);
      end
      add("reopen4_fault",  I_STOP | I_OBS,               1,        O_FT);
      add("fault_sticky",   I_OPEN | I_STOP | I_LO,       5,        O_FT);

      // Power-on reset state.
      #12;
      exp_q.push_back(O_DC);
      compare_head("reset_state");
      #5;
      reset = 1'b1;
      @(posedge clk);
      #1;
      exp_q.push_back(O_DC);
      compare_head("reset_release");

      foreach (steps[i]) begin
         run_step(steps[i].name, steps[i].in, steps[i].cycles, steps[i].exp);
      end
      async_reset("fault_clear");

      // Opening timeout: 20 cycles in OPENING without lim_open.
      run_step("to_start",      I_OPEN | I_STOP | I_LC, 1,        O_MO);
      run_step("to_last",       I_STOP,                 MOVE-1,   O_MO);
      run_step("to_fault",      I_STOP,                 1,        O_FT);
      async_reset("to_reset");

      // Both limit switches active while closed.
      run_step("both_lim",      I_LO | I_LC,            1,        O_FT);
      run_step("both_lim_hold", I_NONE,                 3,        O_FT);
      async_reset("both_lim_reset");

      // Asynchronous reset in the middle of closing.
      run_step("ar_start",      I_OPEN | I_STOP | I_LC, 1,        O_MO);
      run_step("ar_open",       I_STOP | I_LO,          1,        O_CR);
      run_step("ar_dwell",      I_STOP | I_LO,          DWELL-1,  O_NONE);
      run_step("ar_closing",    I_STOP,                 3,        O_MC);
      async_reset("ar_mid_close");
      run_step("ar_after",      I_OPEN | I_STOP | I_LC, 1,        O_MO);

      // ---------------- report ----------------
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_door_sequencer
